// File: rtl/display_mode_sequencer_if.sv
// Purpose: groups the switch/vsync inputs and the mode-control outputs of display_mode_sequencer.
// Latency: none (wiring only).
// Backpressure: none; all signals are level or single-cycle pulses in the pixel clock domain.
interface display_mode_sequencer_if;
    // Raw asynchronous inputs
    logic       sw_grayscale;
    logic       sw_sobel;
    logic       sw_filter;
    logic       sw_canny;
    logic       vsync_raw;
    // Registered mode-control outputs
    logic [2:0] mode_active;
    logic [4:0] mode_onehot;
    logic [2:0] pipe_idx;
    logic       blank_out;
    logic       pipe_flush;
    logic       mode_changed;

    // master drives the switches/vsync and observes the mode outputs
    modport master (
        output sw_grayscale, sw_sobel, sw_filter, sw_canny, vsync_raw,
        input  mode_active, mode_onehot, pipe_idx, blank_out, pipe_flush, mode_changed
    );

    // slave is the sequencer itself
    modport slave (
        input  sw_grayscale, sw_sobel, sw_filter, sw_canny, vsync_raw,
        output mode_active, mode_onehot, pipe_idx, blank_out, pipe_flush, mode_changed
    );
endinterface

// File: rtl/display_mode_sequencer.sv
// Purpose: debounces the display-mode switches and applies the selected VGA mode only at frame edges, with optional blanking.
// Latency: switch->stable ~DEBOUNCE_CYCLES+4 cycles; synchronized vsync fall -> applied mode 1 cycle (raw edge -> apply 3 cycles).
// Backpressure: none; a mode request waits in PENDING until the next frame edge, changes during blanking wait for RUN.
// Ports: clk_25_vga (only clock), rst (sync, active high), io (slave modport: raw switches/vsync in, mode/idx/blank/flush out).
module display_mode_sequencer #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int BLANK_FRAMES    = 1,
    parameter int IDX_ORIG        = 6,
    parameter int IDX_GRAY        = 6,
    parameter int IDX_GAUSS       = 2,
    parameter int IDX_SOBEL       = 4,
    parameter int IDX_CANNY       = 6
) (
    input logic               clk_25_vga,
    input logic               rst,
    display_mode_sequencer_if.slave io
);

    localparam int                CNT_W      = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX    = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [15:0]       BLANK_LAST = 16'((BLANK_FRAMES > 0) ? BLANK_FRAMES - 1 : 0);

    typedef enum logic [1:0] {ST_RUN, ST_PENDING, ST_BLANK} state_t;

    // Switch vector bit order: [0]=grayscale [1]=filter [2]=sobel [3]=canny
    logic [3:0]       sw_meta_q,   sw_meta_d;
    logic [3:0]       sw_sync_q,   sw_sync_d;
    logic [3:0]       sw_prev_q,   sw_prev_d;
    logic [3:0]       sw_stable_q, sw_stable_d;
    logic [CNT_W-1:0] cnt_q,       cnt_d;
    logic             vs_meta_q,   vs_meta_d;
    logic             vs_sync_q,   vs_sync_d;
    logic             vs_prev_q,   vs_prev_d;
    state_t           state_q,     state_d;
    logic [2:0]       mode_q,      mode_d;
    logic [4:0]       onehot_q,    onehot_d;
    logic [2:0]       idx_q,       idx_d;
    logic             blank_q,     blank_d;
    logic             flush_q,     flush_d;
    logic [15:0]      blank_cnt_q, blank_cnt_d;

    logic             vs_fall;
    logic [2:0]       target;

    function automatic logic [2:0] idx_of(input logic [2:0] m);
        case (m)
            3'd1:    idx_of = 3'(IDX_GRAY);
            3'd2:    idx_of = 3'(IDX_GAUSS);
            3'd3:    idx_of = 3'(IDX_SOBEL);
            3'd4:    idx_of = 3'(IDX_CANNY);
            default: idx_of = 3'(IDX_ORIG);
        endcase
    endfunction

    assign vs_fall = vs_prev_q & ~vs_sync_q;

    // Grayscale deliberately outranks filter even though its mode number is lower.
    always_comb begin
        target = 3'd0;
        if (sw_stable_q[3])      target = 3'd4;
        else if (sw_stable_q[2]) target = 3'd3;
        else if (sw_stable_q[0]) target = 3'd1;
        else if (sw_stable_q[1]) target = 3'd2;
    end

    always_comb begin
        sw_meta_d   = {io.sw_canny, io.sw_sobel, io.sw_filter, io.sw_grayscale};
        sw_sync_d   = sw_meta_q;
        sw_prev_d   = sw_sync_q;
        sw_stable_d = sw_stable_q;
        cnt_d       = cnt_q;
        vs_meta_d   = io.vsync_raw;
        vs_sync_d   = vs_meta_q;
        vs_prev_d   = vs_sync_q;
        state_d     = state_q;
        mode_d      = mode_q;
        onehot_d    = onehot_q;
        idx_d       = idx_q;
        blank_d     = blank_q;
        flush_d     = 1'b0;
        blank_cnt_d = blank_cnt_q;

        // Debounce: counter saturates at CNT_MAX and keeps re-latching the same vector.
        if (sw_sync_q != sw_prev_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_MAX) begin
            sw_stable_d = sw_sync_q;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end

        case (state_q)
            ST_RUN: begin
                if (target != mode_q) state_d = ST_PENDING;
            end
            ST_PENDING: begin
                // A request withdrawn before the frame edge leaves no trace.
                if (target == mode_q) begin
                    state_d = ST_RUN;
                end else if (vs_fall) begin
                    mode_d   = target;
                    onehot_d = 5'b00001 << target;
                    idx_d    = idx_of(target);
                    flush_d  = 1'b1;
                    if (BLANK_FRAMES > 0) begin
                        blank_d     = 1'b1;
                        blank_cnt_d = '0;
                        state_d     = ST_BLANK;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_BLANK: begin
                if (vs_fall) begin
                    if (blank_cnt_q == BLANK_LAST) begin
                        blank_d = 1'b0;
                        state_d = ST_RUN;
                    end else begin
                        blank_cnt_d = blank_cnt_q + 16'd1;
                    end
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk_25_vga) begin
        if (rst) begin
            sw_meta_q   <= '0;
            sw_sync_q   <= '0;
            sw_prev_q   <= '0;
            sw_stable_q <= '0;
            cnt_q       <= '0;
            vs_meta_q   <= 1'b0;
            vs_sync_q   <= 1'b0;
            vs_prev_q   <= 1'b0;
            state_q     <= ST_RUN;
            mode_q      <= 3'd0;
            onehot_q    <= 5'b00001;
            idx_q       <= 3'(IDX_ORIG);
            blank_q     <= 1'b0;
            flush_q     <= 1'b0;
            blank_cnt_q <= '0;
        end else begin
            sw_meta_q   <= sw_meta_d;
            sw_sync_q   <= sw_sync_d;
            sw_prev_q   <= sw_prev_d;
            sw_stable_q <= sw_stable_d;
            cnt_q       <= cnt_d;
            vs_meta_q   <= vs_meta_d;
            vs_sync_q   <= vs_sync_d;
            vs_prev_q   <= vs_prev_d;
            state_q     <= state_d;
            mode_q      <= mode_d;
            onehot_q    <= onehot_d;
            idx_q       <= idx_d;
            blank_q     <= blank_d;
            flush_q     <= flush_d;
            blank_cnt_q <= blank_cnt_d;
        end
    end

    assign io.mode_active  = mode_q;
    assign io.mode_onehot  = onehot_q;
    assign io.pipe_idx     = idx_q;
    assign io.blank_out    = blank_q;
    assign io.pipe_flush   = flush_q;
    assign io.mode_changed = flush_q;

endmodule

// File: tb/tb_display_mode_sequencer.sv
module tb_display_mode_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total  = 0;
    int   passed = 0;

    display_mode_sequencer_if io();

    display_mode_sequencer #(
        .DEBOUNCE_CYCLES(4),
        .BLANK_FRAMES   (1),
        .IDX_ORIG       (6),
        .IDX_GRAY       (6),
        .IDX_GAUSS      (2),
        .IDX_SOBEL      (4),
        .IDX_CANNY      (6)
    ) dut (
        .clk_25_vga(clk),
        .rst       (rst),
        .io        (io)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        io.sw_grayscale = 1'b0;
        io.sw_sobel     = 1'b0;
        io.sw_filter    = 1'b0;
        io.sw_canny     = 1'b0;
        io.vsync_raw    = 1'b1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_inputs();
        repeat (3) tick();
        rst = 1'b0;
        repeat (4) tick();
    endtask

    // Drop vsync; after this returns, the next tick() samples the apply cycle.
    task automatic vs_drop();
        io.vsync_raw = 1'b0;
        repeat (2) tick();
    endtask

    task automatic vs_rise();
        io.vsync_raw = 1'b1;
        repeat (4) tick();
    endtask

    // Runs one frame edge and reports whether any flush/blank was seen.
    task automatic frame_watch(output bit saw_flush, output bit saw_blank);
        saw_flush = 1'b0;
        saw_blank = 1'b0;
        io.vsync_raw = 1'b0;
        repeat (6) begin
            tick();
            if (io.pipe_flush !== 1'b0 || io.mode_changed !== 1'b0) saw_flush = 1'b1;
            if (io.blank_out !== 1'b0) saw_blank = 1'b1;
        end
        io.vsync_raw = 1'b1;
        repeat (4) begin
            tick();
            if (io.pipe_flush !== 1'b0 || io.mode_changed !== 1'b0) saw_flush = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_inputs();
        repeat (3) tick();
        total++; if (io.mode_active !== 3'd0) $display("FAIL reset_mode got %0d want 0", io.mode_active); else passed++;
        total++; if (io.mode_onehot !== 5'b00001) $display("FAIL reset_onehot got %b want 00001", io.mode_onehot); else passed++;
        total++; if (io.pipe_idx !== 3'd6) $display("FAIL reset_idx got %0d want 6", io.pipe_idx); else passed++;
        total++; if (io.blank_out !== 1'b0) $display("FAIL reset_blank got %b want 0", io.blank_out); else passed++;
        total++; if (io.pipe_flush !== 1'b0) $display("FAIL reset_flush got %b want 0", io.pipe_flush); else passed++;
        total++; if (io.mode_changed !== 1'b0) $display("FAIL reset_changed got %b want 0", io.mode_changed); else passed++;
        rst = 1'b0;
        repeat (4) tick();
        total++; if (io.mode_active !== 3'd0 || io.pipe_flush !== 1'b0) $display("FAIL post_reset got mode=%0d flush=%b want 0/0", io.mode_active, io.pipe_flush); else passed++;
    endtask

    task automatic test_sobel_apply();
        do_reset();
        io.sw_sobel = 1'b1;
        repeat (15) tick();
        total++; if (io.mode_active !== 3'd0 || io.blank_out !== 1'b0) $display("FAIL sobel_pending got mode=%0d blank=%b want 0/0", io.mode_active, io.blank_out); else passed++;
        vs_drop();
        total++; if (io.mode_active !== 3'd0 || io.pipe_flush !== 1'b0) $display("FAIL sobel_pre_apply got mode=%0d flush=%b want 0/0", io.mode_active, io.pipe_flush); else passed++;
        tick();
        total++; if (io.mode_active !== 3'd3) $display("FAIL sobel_mode got %0d want 3", io.mode_active); else passed++;
        total++; if (io.mode_onehot !== 5'b01000) $display("FAIL sobel_onehot got %b want 01000", io.mode_onehot); else passed++;
        total++; if (io.pipe_idx !== 3'd4) $display("FAIL sobel_idx got %0d want 4", io.pipe_idx); else passed++;
        total++; if (io.pipe_flush !== 1'b1 || io.mode_changed !== 1'b1) $display("FAIL sobel_pulse got flush=%b chg=%b want 1/1", io.pipe_flush, io.mode_changed); else passed++;
        total++; if (io.blank_out !== 1'b1) $display("FAIL sobel_blank_rise got %b want 1", io.blank_out); else passed++;
        tick();
        total++; if (io.pipe_flush !== 1'b0 || io.mode_changed !== 1'b0) $display("FAIL sobel_pulse_width got flush=%b chg=%b want 0/0", io.pipe_flush, io.mode_changed); else passed++;
        vs_rise();
        total++; if (io.blank_out !== 1'b1) $display("FAIL sobel_blank_hold got %b want 1", io.blank_out); else passed++;
        vs_drop();
        total++; if (io.blank_out !== 1'b1) $display("FAIL sobel_blank_at_edge got %b want 1", io.blank_out); else passed++;
        tick();
        total++; if (io.blank_out !== 1'b0 || io.pipe_flush !== 1'b0 || io.mode_active !== 3'd3) $display("FAIL sobel_blank_end got blank=%b flush=%b mode=%0d want 0/0/3", io.blank_out, io.pipe_flush, io.mode_active); else passed++;
        vs_rise();
    endtask

    task automatic test_glitch();
        bit sf, sb;
        do_reset();
        for (int i = 0; i < 10; i++) begin
            io.sw_canny = ~io.sw_canny;
            repeat (2) tick();
        end
        io.sw_canny = 1'b0;
        repeat (10) tick();
        frame_watch(sf, sb);
        total++; if (io.mode_active !== 3'd0) $display("FAIL glitch_mode got %0d want 0", io.mode_active); else passed++;
        total++; if (sf !== 1'b0 || sb !== 1'b0) $display("FAIL glitch_pulses got flush=%b blank=%b want 0/0", sf, sb); else passed++;
    endtask

    task automatic test_priority_and_blank_defer();
        do_reset();
        io.sw_filter = 1'b1;
        io.sw_canny  = 1'b1;
        repeat (15) tick();
        vs_drop();
        tick();
        total++; if (io.mode_active !== 3'd4 || io.pipe_idx !== 3'd6 || io.mode_onehot !== 5'b10000) $display("FAIL canny_apply got mode=%0d idx=%0d oh=%b want 4/6/10000", io.mode_active, io.pipe_idx, io.mode_onehot); else passed++;
        total++; if (io.pipe_flush !== 1'b1) $display("FAIL canny_flush got %b want 1", io.pipe_flush); else passed++;
        // Drop canny while blanking; the new target must wait until blank ends.
        io.sw_canny = 1'b0;
        io.vsync_raw = 1'b1;
        repeat (16) tick();
        total++; if (io.blank_out !== 1'b1 || io.mode_active !== 3'd4) $display("FAIL defer_blank got blank=%b mode=%0d want 1/4", io.blank_out, io.mode_active); else passed++;
        vs_drop();
        tick();
        total++; if (io.blank_out !== 1'b0 || io.pipe_flush !== 1'b0 || io.mode_active !== 3'd4) $display("FAIL defer_edge got blank=%b flush=%b mode=%0d want 0/0/4", io.blank_out, io.pipe_flush, io.mode_active); else passed++;
        vs_rise();
        vs_drop();
        tick();
        total++; if (io.mode_active !== 3'd2 || io.pipe_idx !== 3'd2 || io.mode_onehot !== 5'b00100) $display("FAIL gauss_apply got mode=%0d idx=%0d oh=%b want 2/2/00100", io.mode_active, io.pipe_idx, io.mode_onehot); else passed++;
        total++; if (io.pipe_flush !== 1'b1 || io.blank_out !== 1'b1) $display("FAIL gauss_pulse got flush=%b blank=%b want 1/1", io.pipe_flush, io.blank_out); else passed++;
        vs_rise();
        vs_drop();
        tick();
        total++; if (io.blank_out !== 1'b0 || io.mode_active !== 3'd2) $display("FAIL gauss_blank_end got blank=%b mode=%0d want 0/2", io.blank_out, io.mode_active); else passed++;
        vs_rise();
    endtask

    task automatic test_pending_cancel();
        bit sf, sb;
        do_reset();
        io.sw_grayscale = 1'b1;
        repeat (15) tick();
        io.sw_grayscale = 1'b0;
        repeat (15) tick();
        frame_watch(sf, sb);
        total++; if (io.mode_active !== 3'd0 || io.pipe_idx !== 3'd6) $display("FAIL cancel_mode got mode=%0d idx=%0d want 0/6", io.mode_active, io.pipe_idx); else passed++;
        total++; if (sf !== 1'b0 || sb !== 1'b0) $display("FAIL cancel_pulses got flush=%b blank=%b want 0/0", sf, sb); else passed++;
    endtask

    task automatic test_reset_in_blank();
        bit sf, sb;
        do_reset();
        io.sw_sobel = 1'b1;
        repeat (15) tick();
        vs_drop();
        tick();
        total++; if (io.blank_out !== 1'b1 || io.mode_active !== 3'd3) $display("FAIL rib_enter got blank=%b mode=%0d want 1/3", io.blank_out, io.mode_active); else passed++;
        io.vsync_raw = 1'b1;
        repeat (3) tick();
        rst = 1'b1;
        io.sw_sobel = 1'b0;
        tick();
        total++; if (io.blank_out !== 1'b0 || io.mode_active !== 3'd0 || io.pipe_idx !== 3'd6) $display("FAIL rib_reset got blank=%b mode=%0d idx=%0d want 0/0/6", io.blank_out, io.mode_active, io.pipe_idx); else passed++;
        tick();
        rst = 1'b0;
        repeat (10) tick();
        frame_watch(sf, sb);
        total++; if (sf !== 1'b0 || sb !== 1'b0 || io.mode_active !== 3'd0) $display("FAIL rib_after got flush=%b blank=%b mode=%0d want 0/0/0", sf, sb, io.mode_active); else passed++;
    endtask

    task automatic test_gray_priority();
        do_reset();
        io.sw_grayscale = 1'b1;
        io.sw_filter    = 1'b1;
        repeat (15) tick();
        vs_drop();
        tick();
        total++; if (io.mode_active !== 3'd1 || io.pipe_idx !== 3'd6 || io.mode_onehot !== 5'b00010) $display("FAIL gray_prio got mode=%0d idx=%0d oh=%b want 1/6/00010", io.mode_active, io.pipe_idx, io.mode_onehot); else passed++;
        vs_rise();
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_sobel_apply();
        test_glitch();
        test_priority_and_blank_defer();
        test_pending_cancel();
        test_reset_in_blank();
        test_gray_priority();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/display_mode_sequencer.md
Name: display_mode_sequencer

Overview:
Owns the display-mode selection for the VGA output datapath (original / grayscale / gaussian-unsharp / sobel / canny). It synchronizes and debounces the four mode switches and priority-encodes them. Mode changes are applied only at a frame boundary, with an optional blanking interval so the line-buffered filters refill before their output is shown. It drives the final output mux selection, the per-mode pipeline-delay tap index and a one-cycle pipeline flush, all in the VGA pixel clock domain.

Parameters:
DEBOUNCE_CYCLES, 250000, cycles a synchronized switch vector must stay unchanged before it is accepted (10 ms at 25 MHz); must be >= 1
BLANK_FRAMES, 1, number of full frames forced black after a mode change; 0 means no blanking
IDX_ORIG, 6, delay tap index for the original-colour path
IDX_GRAY, 6, delay tap index for the grayscale path
IDX_GAUSS, 2, delay tap index for the gaussian/unsharp path
IDX_SOBEL, 4, delay tap index for the sobel path
IDX_CANNY, 6, delay tap index for the canny path

Ports:
clk_25_vga  in  1  VGA pixel clock; the only clock
rst  in  1  synchronous active-high reset
sw_grayscale  in  1  raw switch input, asynchronous
sw_sobel  in  1  raw switch input, asynchronous
sw_filter  in  1  raw switch input, asynchronous
sw_canny  in  1  raw switch input, asynchronous
vsync_raw  in  1  VGA vertical sync, active low; a falling edge marks the frame boundary
mode_active  out  3  applied mode: 0=orig, 1=gray, 2=gauss, 3=sobel, 4=canny
mode_onehot  out  5  one-hot form of mode_active; bit n set when mode_active == n
pipe_idx  out  3  IDX_* value for mode_active
blank_out  out  1  forces the RGB output to black while high
pipe_flush  out  1  one-cycle pulse at a mode apply; clears the filter line buffers and delay chains
mode_changed  out  1  one-cycle pulse, coincident with pipe_flush

Behaviour:
- Reset values: mode_active=0, mode_onehot=5'b00001, pipe_idx=IDX_ORIG, blank_out=0, pipe_flush=0, mode_changed=0. State=RUN. Synchronizers, debounce counter and vsync edge register are cleared to 0. Reset applies mid-blank or mid-pending with no residual pulse.
- Synchronization: each switch and vsync_raw pass through a 2-flop synchronizer.
- Debounce: the counter resets whenever the synchronized 4-bit switch vector differs from its previous-cycle value. When the counter reaches DEBOUNCE_CYCLES, the vector is latched as sw_stable.
- Priority encode of sw_stable into target: canny (4) > sobel (3) > grayscale (1) > filter (2) > none (0).
- Frame edge: vs_fall = synchronized vsync was 1 last cycle and is 0 this cycle.
- States:
  - RUN: if target != mode_active, go to PENDING.
  - PENDING: if target == mode_active, return to RUN with no pulses. On vs_fall, apply the current target; go to BLANK if BLANK_FRAMES>0, otherwise go to RUN.
  - BLANK: blank_out=1. Count vs_fall events. At the BLANK_FRAMES-th vs_fall, blank_out=0 from the next cycle and the state goes to RUN.
- Apply: in the cycle after the vs_fall is sampled, mode_active, mode_onehot and pipe_idx update together, and pipe_flush and mode_changed are high for exactly that one cycle. blank_out rises in the same cycle (when BLANK_FRAMES>0).
- A target change during BLANK does not cut the blank short. It is evaluated in RUN afterwards and applied at a later frame edge, so at most one apply happens per frame edge.
- A switch change that becomes stable in the same cycle as vs_fall is not applied at that edge; it waits for the next frame edge.
- The outputs are registered; there is no combinational path from any input to any output.

Test Plan:
- Reset held 3 cycles, switches all 0 -> mode_active=0, mode_onehot=00001, pipe_idx=6, blank_out=0, no pulses.
- DEBOUNCE_CYCLES=4, BLANK_FRAMES=1: set sw_sobel, then a vsync falling edge -> one cycle after the sampled edge mode_active=3, pipe_idx=4, pipe_flush=1 for 1 cycle, blank_out=1 until 1 cycle after the next vs_fall.
- sw_canny toggled every 2 cycles for 20 cycles, then held low -> sw_stable never changes, mode_active stays 0, no pulses.
- sw_filter and sw_canny set together -> applied mode 4; then drop sw_canny -> mode 2 with pipe_idx=2 at the next edge after blanking.
- Set sw_grayscale and let it become stable, then clear it and let it become stable before any vs_fall -> PENDING cancelled, no pipe_flush, mode_active stays 0.
- Reset asserted while in BLANK -> blank_out=0 next cycle, mode_active=0, and no pulse at the following vs_fall.
